// File: rtl/br_predict_ctrl.sv
// br_predict_ctrl: 2-bit counter branch predictor control, in-order resolve.
// Define BP_GSHARE_EN for gshare indexing with a speculative, repairable GHR.
module br_predict_ctrl #(
  parameter int QDEPTH = 4,
  parameter int HIST   = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_valid,
  input  logic [15:0] fetch_pc,
  output logic        fetch_stall,
  output logic        predict_taken,
  input  logic        resolve_valid,
  input  logic        resolve_taken,
  output logic        resolve_ready,
  output logic        flush,
  output logic [5:0]  br_read_index,
  input  logic [1:0]  br_dataout,
  output logic        br_write,
  output logic [5:0]  br_write_index,
  output logic [1:0]  br_datain
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unused_hist = HIST;

  typedef struct packed {
    logic [5:0]      idx;
`ifdef BP_GSHARE_EN
    logic [HIST-1:0] snap;
`endif
    logic            pred;
  } bq_t;

  typedef enum logic {IDLE, UPDATE} st_t;

  st_t           state;
  bq_t           q [QDEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic [5:0]    upd_idx;
  logic          upd_taken;

  logic [5:0]    fetch_idx;
  logic          full;
  logic          empty;
  logic          res_hs;
  logic          mispred;
  logic          push;
  logic          sat_hi;
  logic          sat_lo;
  bq_t           head_e;
  bq_t           new_e;
  logic          unused_pc;

`ifdef BP_GSHARE_EN
  logic [HIST-1:0] ghr;
`endif

  assign unused_pc = ^{fetch_pc[15:7], fetch_pc[0]};

  // Fetch index: PC word bits, optionally hashed with global history.
  always_comb begin
`ifdef BP_GSHARE_EN
    fetch_idx = fetch_pc[6:1] ^ ghr;
`else
    fetch_idx = fetch_pc[6:1];
`endif
  end

  // Queue status, handshakes and the entry pushed on accept.
  always_comb begin
    head_e      = q[head];
    full        = (count == (PW+1)'(QDEPTH));
    empty       = (count == '0);
    fetch_stall = full | (state == UPDATE);
    resolve_ready = (state == IDLE) & ~empty;
    res_hs      = resolve_valid & resolve_ready;
    mispred     = res_hs & (resolve_taken != head_e.pred);
    flush       = mispred;
    push        = fetch_valid & ~fetch_stall & ~mispred;
    predict_taken = br_dataout[1];
    new_e.idx   = fetch_idx;
`ifdef BP_GSHARE_EN
    new_e.snap  = ghr;
`endif
    new_e.pred  = br_dataout[1];
  end

  // Array port muxing and saturating counter update.
  always_comb begin
    sat_hi         = (br_dataout == 2'b11);
    sat_lo         = (br_dataout == 2'b00);
    br_read_index  = (state == UPDATE) ? upd_idx : fetch_idx;
    br_write       = (state == UPDATE) & ~reset;
    br_write_index = (state == UPDATE) ? upd_idx : 6'd0;
    br_datain      = 2'b00;
    if (state == UPDATE) begin
      unique case (1'b1)
        upd_taken & ~sat_hi:  br_datain = br_dataout + 2'd1;
        upd_taken & sat_hi:   br_datain = 2'b11;
        ~upd_taken & ~sat_lo: br_datain = br_dataout - 2'd1;
        ~upd_taken & sat_lo:  br_datain = 2'b00;
      endcase
    end
  end

  // Control FSM, queue pointers and pending counter update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      upd_idx   <= 6'd0;
      upd_taken <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (res_hs) begin
            state     <= UPDATE;
            upd_idx   <= head_e.idx;
            upd_taken <= resolve_taken;
          end
          if (mispred) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
          end else begin
            if (res_hs)
              head <= head + 1'b1;
            if (push)
              tail <= tail + 1'b1;
            if (push & ~res_hs)
              count <= count + 1'b1;
            else if (res_hs & ~push)
              count <= count - 1'b1;
          end
        end
        UPDATE: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Entry storage; only written on an accepted fetch.
  always_ff @(posedge clk) begin
    if (!reset && push)
      q[tail] <= new_e;
  end

`ifdef BP_GSHARE_EN
  // Speculative history: shift on accept, repair from snapshot on mispredict.
  always_ff @(posedge clk) begin
    if (reset)
      ghr <= '0;
    else if (mispred)
      ghr <= {head_e.snap[HIST-2:0], resolve_taken};
    else if (push)
      ghr <= {ghr[HIST-2:0], br_dataout[1]};
  end
`endif

endmodule
